tpu_ctrl: RTL and testbench



---
 rtl/tpu_ctrl_pkg.sv | 30 +++
 rtl/tpu_ctrl_if.sv | 31 +++
 rtl/tpu_ctrl_tile_addr_gen.sv | 91 +++++++++
 rtl/tpu_ctrl.sv | 115 +++++++++++
 tb/tb_tpu_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_ctrl_pkg.sv
// Shared constants, state encoding and tile-count helper for the TPU
// sequencing controller.
package tpu_ctrl_pkg;

  localparam int ARRAY_DIM       = 4;
  localparam int DRAIN_CYC       = 2 * ARRAY_DIM - 1;
  localparam int GBUFF_INDX_SIZE = 8;

  localparam int DIM_W  = 4;  // width of m, n, k
  localparam int TILE_W = 3;  // tile counts 0..4
  localparam int ROW_W  = 2;  // tile-local row / tile index 0..3
  localparam int DC_W   = 3;  // drain counter 0..6

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Number of ARRAY_DIM-wide tiles covering a dimension (ceil(dim/4)).
  function automatic logic [TILE_W-1:0] tile_count(input logic [DIM_W-1:0] dim);
    logic [DIM_W:0] sum;
    sum = {1'b0, dim} + (DIM_W + 1)'(ARRAY_DIM - 1);
    return sum[DIM_W:2];
  endfunction

endpackage

// File: rtl/tpu_ctrl_if.sv
// Command and buffer-index bus between the command source and tpu_ctrl.
interface tpu_ctrl_if;
  import tpu_ctrl_pkg::*;

  logic                       start;
  logic [DIM_W-1:0]           m;
  logic [DIM_W-1:0]           n;
  logic [DIM_W-1:0]           k;
  logic [GBUFF_INDX_SIZE-1:0] addr_a;
  logic [GBUFF_INDX_SIZE-1:0] addr_b;
  logic [GBUFF_INDX_SIZE-1:0] addr_c;
  logic                       wr_en_c;
  logic                       acc_clr;
  logic                       feed_valid;
  logic [ROW_W-1:0]           out_row;
  logic                       busy;
  logic                       done;

  modport master (
    output start, m, n, k,
    input  addr_a, addr_b, addr_c, wr_en_c, acc_clr, feed_valid,
           out_row, busy, done
  );

  modport slave (
    input  start, m, n, k,
    output addr_a, addr_b, addr_c, wr_en_c, acc_clr, feed_valid,
           out_row, busy, done
  );

endinterface

// File: rtl/tpu_ctrl_tile_addr_gen.sv
// Tile/row/k counters and buffer index arithmetic. Address outputs are
// registered from the next-cycle counter values, so they line up with the
// state the FSM enters on the same edge.
module tile_addr_gen
  import tpu_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,       // command accepted: restart at tile (0,0)
  input  logic                       kk_run,     // currently in FEED
  input  logic                       r_run,      // currently in WRITE
  input  logic                       tile_adv,   // last WRITE row of a tile
  input  logic                       feed_nxt,   // next cycle is FEED
  input  logic                       write_nxt,  // next cycle is WRITE
  input  logic [DIM_W-1:0]           dim_m,
  input  logic [DIM_W-1:0]           dim_k,
  input  logic [TILE_W-1:0]          mt,
  input  logic [TILE_W-1:0]          nt,
  output logic [DIM_W-1:0]           kk,
  output logic [ROW_W-1:0]           r,
  output logic                       last_tile,
  output logic [GBUFF_INDX_SIZE-1:0] addr_a,
  output logic [GBUFF_INDX_SIZE-1:0] addr_b,
  output logic [GBUFF_INDX_SIZE-1:0] addr_c,
  output logic                       wr_en_c,
  output logic [ROW_W-1:0]           out_row
);

  logic [ROW_W-1:0]           i;
  logic [ROW_W-1:0]           j;
  logic [ROW_W-1:0]           i_n;
  logic [ROW_W-1:0]           j_n;
  logic [ROW_W-1:0]           r_n;
  logic [DIM_W-1:0]           kk_n;
  logic [TILE_W-1:0]          j_inc;
  logic [GBUFF_INDX_SIZE-1:0] tile_idx;

  assign last_tile = ({1'b0, i} == mt - 1'b1) && ({1'b0, j} == nt - 1'b1);

  // Next counter values; column tile j is inner, row tile i outer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    kk_n  = kk_run ? kk + 1'b1 : '0;
    r_n   = r_run ? r + 1'b1 : '0;
    i_n   = i;
    j_n   = j;
    j_inc = {1'b0, j} + 1'b1;
    if (load) begin
      i_n = '0;
      j_n = '0;
    end else if (tile_adv) begin
      if (j_inc == nt) begin
        j_n = '0;
        i_n = i + 1'b1;
      end else begin
        j_n = j_inc[ROW_W-1:0];
      end
    end
    tile_idx = GBUFF_INDX_SIZE'(i_n) * GBUFF_INDX_SIZE'(nt) + GBUFF_INDX_SIZE'(j_n);
  end

  // Counter state and registered buffer indices.
  always_ff @(posedge clk) begin
    if (rst) begin
      i       <= '0;
      j       <= '0;
      kk      <= '0;
      r       <= '0;
      addr_a  <= '0;
      addr_b  <= '0;
      addr_c  <= '0;
      wr_en_c <= 1'b0;
      out_row <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      i       <= i_n;
      j       <= j_n;
      kk      <= kk_n;
      r       <= r_n;
      addr_a  <= feed_nxt ? GBUFF_INDX_SIZE'(i_n) * GBUFF_INDX_SIZE'(dim_k)
                            + GBUFF_INDX_SIZE'(kk_n) : '0;
      addr_b  <= feed_nxt ? GBUFF_INDX_SIZE'(j_n) * GBUFF_INDX_SIZE'(dim_k)
                            + GBUFF_INDX_SIZE'(kk_n) : '0;
      addr_c  <= write_nxt ? {tile_idx[GBUFF_INDX_SIZE-3:0], r_n} : '0;
      // {i, r} is the global output row i*4 + r; rows past m are padding.
      wr_en_c <= write_nxt && ({i_n, r_n} < dim_m);
      out_row <= write_nxt ? r_n : '0;
    end
  end

endmodule

// File: rtl/tpu_ctrl.sv
// Sequencing controller: walks the output matrix tile by tile, issuing
// buffer read indices, array clear/feed strobes and result-row writes.
module tpu_ctrl
  import tpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  tpu_ctrl_if.slave  bus
);

  state_t            state;
  state_t            state_n;
  logic [DC_W-1:0]   dc;
  logic [DC_W-1:0]   dc_n;
  logic [DIM_W-1:0]  dim_m;
  logic [DIM_W-1:0]  dim_k;
  logic [TILE_W-1:0] mt;
  logic [TILE_W-1:0] nt;
  logic [DIM_W-1:0]  kk;
  logic [ROW_W-1:0]  r;
  logic              last_tile;
  logic              load;
  logic              kk_run;
  logic              r_run;
  logic              tile_adv;
  logic              feed_nxt;
  logic              write_nxt;

  // Next-state logic and counter enables.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    dc_n      = (state == DRAIN) ? dc + 1'b1 : '0;
    kk_run    = (state == FEED);
    r_run     = (state == WRITE);
    tile_adv  = (state == WRITE) && (r == ROW_W'(ARRAY_DIM - 1));
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load = 1'b1;
          if (bus.m == '0 || bus.n == '0 || bus.k == '0) state_n = DONE;
          else                                            state_n = CLR;
        end
      end
      CLR:   state_n = FEED;
      FEED:  if (kk == dim_k - 1'b1) state_n = DRAIN;
      DRAIN: if (dc == DC_W'(DRAIN_CYC - 1)) state_n = WRITE;
      WRITE: if (tile_adv) state_n = last_tile ? DONE : CLR;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    feed_nxt  = (state_n == FEED);
    write_nxt = (state_n == WRITE);
  end

  // State, drain counter and command latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dc    <= '0;
      dim_m <= '0;
      dim_k <= '0;
      mt    <= '0;
      nt    <= '0;
    end else begin
      state <= state_n;
      dc    <= dc_n;
      if (load) begin
        dim_m <= bus.m;
        dim_k <= bus.k;
        mt    <= tile_count(bus.m);
        nt    <= tile_count(bus.n);
      end
    end
  end

  // Registered control strobes; feed_valid trails FEED by the buffer read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.acc_clr    <= 1'b0;
      bus.feed_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.acc_clr    <= (state_n == CLR);
      bus.feed_valid <= (state == FEED);
      bus.busy       <= (state_n != IDLE);
      bus.done       <= (state_n == DONE);
    end
  end

  tile_addr_gen u_addr (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .kk_run    (kk_run),
    .r_run     (r_run),
    .tile_adv  (tile_adv),
    .feed_nxt  (feed_nxt),
    .write_nxt (write_nxt),
    .dim_m     (dim_m),
    .dim_k     (dim_k),
    .mt        (mt),
    .nt        (nt),
    .kk        (kk),
    .r         (r),
    .last_tile (last_tile),
    .addr_a    (bus.addr_a),
    .addr_b    (bus.addr_b),
    .addr_c    (bus.addr_c),
    .wr_en_c   (bus.wr_en_c),
    .out_row   (bus.out_row)
  );

endmodule

// File: tb/tb_tpu_ctrl.sv
// Directed bench for tpu_ctrl: each command is traced cycle by cycle
// (cycle 0 = start cycle) and checked against hand-derived timing.
module tb_tpu_ctrl;
  import tpu_ctrl_pkg::*;

  localparam int MAXC = 512;

  logic clk;
  logic rst;
  tpu_ctrl_if bus ();

  tpu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int done_cyc;
  int n_cyc;

  logic                       acc_t   [0:MAXC-1];
  logic                       feed_t  [0:MAXC-1];
  logic                       wr_t    [0:MAXC-1];
  logic                       busy_t  [0:MAXC-1];
  logic                       done_t  [0:MAXC-1];
  logic [GBUFF_INDX_SIZE-1:0] a_t     [0:MAXC-1];
  logic [GBUFF_INDX_SIZE-1:0] b_t     [0:MAXC-1];
  logic [GBUFF_INDX_SIZE-1:0] c_t     [0:MAXC-1];
  logic [ROW_W-1:0]           row_t   [0:MAXC-1];

  // Issue one command in cycle 0 and record every output per cycle.
  // glitch_cyc: cycle in which start is pulsed again with other dims.
  // rst_cyc: cycle in which rst is driven high. Capture stops tail cycles
  // after done, or after max_cyc cycles.
  task automatic run_cmd(input logic [DIM_W-1:0] mm, input logic [DIM_W-1:0] nn,
                         input logic [DIM_W-1:0] kv, input int max_cyc,
                         input int glitch_cyc, input int rst_cyc, input int tail);
    for (int c = 0; c < MAXC; c++) begin
      acc_t[c] = 0; feed_t[c] = 0; wr_t[c] = 0; busy_t[c] = 0; done_t[c] = 0;
      a_t[c] = '0; b_t[c] = '0; c_t[c] = '0; row_t[c] = '0;
    end
    done_cyc = -1;
    n_cyc    = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      acc_t[c]  = bus.acc_clr;
      feed_t[c] = bus.feed_valid;
      wr_t[c]   = bus.wr_en_c;
      busy_t[c] = bus.busy;
      done_t[c] = bus.done;
      a_t[c]    = bus.addr_a;
      b_t[c]    = bus.addr_b;
      c_t[c]    = bus.addr_c;
      row_t[c]  = bus.out_row;
      n_cyc     = c + 1;
      if (bus.done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c >= done_cyc + tail) break;
      rst = (c == rst_cyc);
      if (c == 0) begin
        bus.start = 1'b1; bus.m = mm; bus.n = nn; bus.k = kv;
      end else if (c == glitch_cyc) begin
        bus.start = 1'b1; bus.m = 4'd1; bus.n = 4'd2; bus.k = 4'd1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.m = '0; bus.n = '0; bus.k = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.acc_clr, bus.feed_valid, bus.wr_en_c, bus.busy, bus.done,
         bus.addr_a, bus.addr_b, bus.addr_c, bus.out_row} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: acc=%b feed=%b wr=%b busy=%b done=%b a=%0d b=%0d c=%0d row=%0d, required all 0",
               bus.acc_clr, bus.feed_valid, bus.wr_en_c, bus.busy, bus.done,
               bus.addr_a, bus.addr_b, bus.addr_c, bus.out_row);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // m=n=k=4: one tile, checked cycle by cycle through two cycles past done.
  task automatic test_single_tile();
    run_cmd(4'd4, 4'd4, 4'd4, 40, -1, -1, 2);
    n_checks++;
    if (done_cyc !== 17) begin
      n_fail++; $display("FAIL single_done_cycle: got %0d, required 17", done_cyc);
    end
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (acc_t[c] !== (c == 1)) begin
        n_fail++; $display("FAIL single_acc_clr c%0d: got %b, required %b", c, acc_t[c], c == 1);
      end
      n_checks++;
      if (feed_t[c] !== (c >= 3 && c <= 6)) begin
        n_fail++; $display("FAIL single_feed_valid c%0d: got %b, required %b", c, feed_t[c], c >= 3 && c <= 6);
      end
      n_checks++;
      if (busy_t[c] !== (c >= 1 && c <= 17)) begin
        n_fail++; $display("FAIL single_busy c%0d: got %b, required %b", c, busy_t[c], c >= 1 && c <= 17);
      end
      n_checks++;
      if (wr_t[c] !== (c >= 13 && c <= 16)) begin
        n_fail++; $display("FAIL single_wr_en c%0d: got %b, required %b", c, wr_t[c], c >= 13 && c <= 16);
      end
      if (c >= 2 && c <= 5) begin
        n_checks++;
        if (a_t[c] !== GBUFF_INDX_SIZE'(c - 2) || b_t[c] !== GBUFF_INDX_SIZE'(c - 2)) begin
          n_fail++; $display("FAIL single_addr_ab c%0d: got a=%0d b=%0d, required %0d", c, a_t[c], b_t[c], c - 2);
        end
      end
      if (c >= 13 && c <= 16) begin
        n_checks++;
        if (c_t[c] !== GBUFF_INDX_SIZE'(c - 13) || row_t[c] !== ROW_W'(c - 13)) begin
          n_fail++; $display("FAIL single_addr_c c%0d: got c=%0d row=%0d, required %0d", c, c_t[c], row_t[c], c - 13);
        end
      end
    end
  endtask

  // m=6, n=8, k=3: four 15-cycle tiles; rows 6,7 of row-tile 1 are padding.
  task automatic test_multi_tile();
    int wr_cnt;
    run_cmd(4'd6, 4'd8, 4'd3, 120, -1, -1, 2);
    n_checks++;
    if (done_cyc !== 61) begin
      n_fail++; $display("FAIL multi_done_cycle: got %0d, required 61", done_cyc);
    end
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 4; r++) begin
        int c;
        c = 15 * t + 12 + r;
        n_checks++;
        if (wr_t[c] !== ((t / 2) * 4 + r < 6) || c_t[c] !== GBUFF_INDX_SIZE'(4 * t + r)) begin
          n_fail++; $display("FAIL multi_write t%0d r%0d: got wr=%b c=%0d, required wr=%b c=%0d",
                             t, r, wr_t[c], c_t[c], (t / 2) * 4 + r < 6, 4 * t + r);
        end
      end
      for (int kv = 0; kv < 3; kv++) begin
        int c;
        c = 15 * t + 2 + kv;
        n_checks++;
        if (a_t[c] !== GBUFF_INDX_SIZE'((t / 2) * 3 + kv) || b_t[c] !== GBUFF_INDX_SIZE'((t % 2) * 3 + kv)) begin
          n_fail++; $display("FAIL multi_read t%0d kk%0d: got a=%0d b=%0d, required a=%0d b=%0d",
                             t, kv, a_t[c], b_t[c], (t / 2) * 3 + kv, (t % 2) * 3 + kv);
        end
      end
    end
    wr_cnt = 0;
    for (int c = 0; c < n_cyc; c++) if (wr_t[c] === 1'b1) wr_cnt++;
    n_checks++;
    if (wr_cnt !== 12) begin
      n_fail++; $display("FAIL multi_write_count: got %0d, required 12", wr_cnt);
    end
  endtask

  // Any zero dimension finishes in cycle 1 with no clear, feed or write.
  task automatic test_zero_dim();
    run_cmd(4'd4, 4'd4, 4'd0, 10, -1, -1, 2);
    n_checks++;
    if (done_cyc !== 1 || busy_t[1] !== 1'b1) begin
      n_fail++; $display("FAIL zero_k_done: got done_cyc=%0d busy=%b, required 1 and 1", done_cyc, busy_t[1]);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({acc_t[c], feed_t[c], wr_t[c]} !== 3'b000) begin
        n_fail++; $display("FAIL zero_k_quiet c%0d: got acc/feed/wr=%b%b%b, required 000", c, acc_t[c], feed_t[c], wr_t[c]);
      end
    end
    run_cmd(4'd0, 4'd5, 4'd5, 10, -1, -1, 2);
    n_checks++;
    if (done_cyc !== 1 || acc_t[1] !== 1'b0) begin
      n_fail++; $display("FAIL zero_m_done: got done_cyc=%0d acc=%b, required 1 and 0", done_cyc, acc_t[1]);
    end
  endtask

  // A second start with other dims during FEED must not disturb the run.
  task automatic test_ignore_start();
    int wr_cnt;
    run_cmd(4'd4, 4'd4, 4'd4, 40, 3, -1, 2);
    n_checks++;
    if (done_cyc !== 17) begin
      n_fail++; $display("FAIL ignore_done_cycle: got %0d, required 17", done_cyc);
    end
    wr_cnt = 0;
    for (int c = 0; c < n_cyc; c++) if (wr_t[c] === 1'b1) wr_cnt++;
    n_checks++;
    if (wr_cnt !== 4 || c_t[16] !== 8'd3 || a_t[5] !== 8'd3) begin
      n_fail++; $display("FAIL ignore_run: got writes=%0d c16=%0d a5=%0d, required 4 3 3", wr_cnt, c_t[16], a_t[5]);
    end
  endtask

  // rst in cycle 14 kills the run mid-WRITE; a fresh command then works.
  task automatic test_rst_mid();
    run_cmd(4'd4, 4'd4, 4'd4, 30, -1, 14, 2);
    n_checks++;
    if (wr_t[13] !== 1'b1 || wr_t[14] !== 1'b1 || done_cyc !== -1) begin
      n_fail++; $display("FAIL rst_pre: got wr13=%b wr14=%b done_cyc=%0d, required 1 1 -1", wr_t[13], wr_t[14], done_cyc);
    end
    for (int c = 15; c < 30; c++) begin
      n_checks++;
      if ({acc_t[c], feed_t[c], wr_t[c], busy_t[c], done_t[c], a_t[c], b_t[c], c_t[c], row_t[c]} !== '0) begin
        n_fail++; $display("FAIL rst_quiet c%0d: got wr=%b busy=%b c=%0d row=%0d, required all 0", c, wr_t[c], busy_t[c], c_t[c], row_t[c]);
      end
    end
    run_cmd(4'd4, 4'd4, 4'd4, 40, -1, -1, 2);
    n_checks++;
    if (done_cyc !== 17 || acc_t[1] !== 1'b1 || wr_t[16] !== 1'b1 || c_t[16] !== 8'd3) begin
      n_fail++; $display("FAIL rst_rerun: got done_cyc=%0d acc1=%b wr16=%b c16=%0d, required 17 1 1 3",
                         done_cyc, acc_t[1], wr_t[16], c_t[16]);
    end
  endtask

  // Start in the cycle right after done is accepted.
  task automatic test_back_to_back();
    run_cmd(4'd1, 4'd1, 4'd1, 40, -1, -1, 0);
    n_checks++;
    if (done_cyc !== 14 || wr_t[10] !== 1'b1 || wr_t[11] !== 1'b0 || c_t[10] !== 8'd0) begin
      n_fail++; $display("FAIL b2b_first: got done_cyc=%0d wr10=%b wr11=%b c10=%0d, required 14 1 0 0",
                         done_cyc, wr_t[10], wr_t[11], c_t[10]);
    end
    run_cmd(4'd4, 4'd4, 4'd4, 40, -1, -1, 2);
    n_checks++;
    if (done_cyc !== 17 || acc_t[1] !== 1'b1 || wr_t[13] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: got done_cyc=%0d acc1=%b wr13=%b, required 17 1 1", done_cyc, acc_t[1], wr_t[13]);
    end
  endtask

  // m=n=k=15: 16 tiles of 27 cycles; last tile reads 45..59, writes 60..62.
  task automatic test_max();
    int wr_cnt;
    run_cmd(4'd15, 4'd15, 4'd15, 500, -1, -1, 2);
    n_checks++;
    if (done_cyc !== 433) begin
      n_fail++; $display("FAIL max_done_cycle: got %0d, required 433", done_cyc);
    end
    for (int kv = 0; kv < 15; kv++) begin
      n_checks++;
      if (a_t[407 + kv] !== GBUFF_INDX_SIZE'(45 + kv) || b_t[407 + kv] !== GBUFF_INDX_SIZE'(45 + kv)) begin
        n_fail++; $display("FAIL max_read kk%0d: got a=%0d b=%0d, required %0d", kv, a_t[407 + kv], b_t[407 + kv], 45 + kv);
      end
    end
    for (int r = 0; r < 4; r++) begin
      n_checks++;
      if (c_t[429 + r] !== GBUFF_INDX_SIZE'(60 + r) || wr_t[429 + r] !== (r < 3)) begin
        n_fail++; $display("FAIL max_write r%0d: got c=%0d wr=%b, required c=%0d wr=%b", r, c_t[429 + r], wr_t[429 + r], 60 + r, r < 3);
      end
    end
    wr_cnt = 0;
    for (int c = 0; c < n_cyc; c++) if (wr_t[c] === 1'b1) wr_cnt++;
    n_checks++;
    if (wr_cnt !== 60) begin
      n_fail++; $display("FAIL max_write_count: got %0d, required 60", wr_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_zero_dim();
    test_ignore_start();
    test_rst_mid();
    test_back_to_back();
    test_max();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
